// File: rtl/melody_pkg.sv
// rtl/melody_pkg.sv - shared state type, ROM entry fields and pitch table for the melody sequencer
package melody_pkg;

    localparam int ENTRY_W    = 8;
    localparam int PITCH_W    = 4;
    localparam int DUR_W      = 4;
    localparam int NOTE_DIV_W = 20;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_PLAY = 2'd2,
        ST_GAP  = 2'd3
    } state_e;

    // Half-period divider per pitch code for a 40 MHz clock: 40e6/(2*f)-1.
    // Code 0 is a rest and never drives the divider.
    function automatic logic [NOTE_DIV_W-1:0] note_div_of(input logic [PITCH_W-1:0] pitch);
        logic [NOTE_DIV_W-1:0] div;
        case (pitch)
            4'd1:    div = 20'd76443;  // C4
            4'd2:    div = 20'd72153;  // C#4
            4'd3:    div = 20'd68103;  // D4
            4'd4:    div = 20'd64281;  // D#4
            4'd5:    div = 20'd60673;  // E4
            4'd6:    div = 20'd57268;  // F4
            4'd7:    div = 20'd54053;  // F#4
            4'd8:    div = 20'd51020;  // G4
            4'd9:    div = 20'd48156;  // G#4
            4'd10:   div = 20'd45453;  // A4
            4'd11:   div = 20'd42902;  // A#4
            4'd12:   div = 20'd40494;  // B4
            4'd13:   div = 20'd38221;  // C5
            4'd14:   div = 20'd36076;  // C#5
            4'd15:   div = 20'd34051;  // D5
            default: div = 20'd0;      // rest
        endcase
        return div;
    endfunction

    function automatic logic [PITCH_W-1:0] entry_pitch(input logic [ENTRY_W-1:0] entry);
        return entry[ENTRY_W-1 -: PITCH_W];
    endfunction

    // A stored duration of 0 plays as one unit so every note is audible.
    function automatic logic [DUR_W-1:0] entry_units(input logic [ENTRY_W-1:0] entry);
        return (entry[DUR_W-1:0] == '0) ? DUR_W'(1) : entry[DUR_W-1:0];
    endfunction

endpackage

// File: rtl/melody_rom.sv
// rtl/melody_rom.sv - synchronous-read song ROM, one cycle of read latency
module melody_rom
    import melody_pkg::*;
#(
    parameter int SONG_LEN = 32,
    parameter int ADDR_W   = $clog2(SONG_LEN)
) (
    input  logic               clk,
    input  logic [ADDR_W-1:0]  addr,
    output logic [ENTRY_W-1:0] data
);

    // Entry = {pitch code, duration units}; unused addresses read as a one-unit rest.
    function automatic logic [ENTRY_W-1:0] song_entry(input logic [7:0] a);
        logic [ENTRY_W-1:0] e;
        case (a)
            8'd0:    e = 8'hA2;
            8'd1:    e = 8'h01;
            8'd2:    e = 8'h10;
            8'd3:    e = 8'hC1;
            8'd4:    e = 8'h52;
            8'd5:    e = 8'h52;
            8'd6:    e = 8'h62;
            8'd7:    e = 8'h82;
            8'd8:    e = 8'h82;
            8'd9:    e = 8'h62;
            8'd10:   e = 8'h52;
            8'd11:   e = 8'h32;
            8'd12:   e = 8'h12;
            8'd13:   e = 8'h12;
            8'd14:   e = 8'h32;
            8'd15:   e = 8'h52;
            8'd16:   e = 8'h53;
            8'd17:   e = 8'h31;
            8'd18:   e = 8'h34;
            8'd19:   e = 8'h02;
            8'd20:   e = 8'hD2;
            8'd21:   e = 8'hE2;
            8'd22:   e = 8'hF4;
            8'd23:   e = 8'hC2;
            8'd24:   e = 8'hA2;
            8'd25:   e = 8'h82;
            8'd26:   e = 8'h64;
            8'd27:   e = 8'h52;
            8'd28:   e = 8'h32;
            8'd29:   e = 8'h12;
            8'd30:   e = 8'h08;
            default: e = 8'h00;
        endcase
        return e;
    endfunction

    // Registered read: data reflects the address presented on the previous edge.
    always_ff @(posedge clk) begin
        data <= song_entry(8'(addr));
    end

endmodule

// File: rtl/melody_sequencer.sv
// rtl/melody_sequencer.sv - steps through the song ROM driving a tone divider, mute and status
module melody_sequencer
    import melody_pkg::*;
#(
    parameter int  BEAT_DIV   = 10_000_000,
    parameter int  GAP_CYCLES = 400_000,
    parameter int  SONG_LEN   = 32,
    localparam int IDX_W      = $clog2(SONG_LEN)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  loop_en,
    output logic [NOTE_DIV_W-1:0] note_div,
    output logic                  mute,
    output logic                  playing,
    output logic [IDX_W-1:0]      note_idx,
    output logic                  done
);

    // One counter serves both the note and the gap, so size it for the longer of the two.
    localparam int PLAY_MAX = 15 * BEAT_DIV;
    localparam int CNT_MAX  = (PLAY_MAX > GAP_CYCLES) ? PLAY_MAX : GAP_CYCLES;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] BEAT_LEN = CNT_W'(BEAT_DIV);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SONG_LEN - 1);
    localparam bit               SKIP_GAP = (GAP_CYCLES == 0);

    state_e                state_q, state_d;
    logic [NOTE_DIV_W-1:0] note_div_q, note_div_d;
    logic                  mute_q, mute_d;
    logic                  playing_q, playing_d;
    logic                  done_q, done_d;
    logic [IDX_W-1:0]      note_idx_q, note_idx_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [CNT_W-1:0]      play_last_q, play_last_d;

    logic [ENTRY_W-1:0]    rom_data;
    logic [PITCH_W-1:0]    rom_pitch;
    logic                  abort;
    logic                  play_end;
    logic                  gap_end;
    logic                  note_end;
    logic                  continue_song;

    // The ROM is addressed with the next index so the entry is ready during LOAD.
    melody_rom #(
        .SONG_LEN (SONG_LEN),
        .ADDR_W   (IDX_W)
    ) u_rom (
        .clk  (clk),
        .addr (note_idx_d),
        .data (rom_data)
    );

    assign rom_pitch     = entry_pitch(rom_data);
    assign abort         = (state_q != ST_IDLE) && stop;
    assign play_end      = (state_q == ST_PLAY) && (cnt_q == play_last_q);
    assign gap_end       = (state_q == ST_GAP) && (cnt_q == GAP_LAST);
    assign note_end      = gap_end || (play_end && SKIP_GAP);
    assign continue_song = (note_idx_q != LAST_IDX) || loop_en;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: stop overrides everything once playback is active.
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (start && !stop) state_d = ST_LOAD;
                ST_LOAD: state_d = ST_PLAY;
                ST_PLAY, ST_GAP: begin
                    if (note_end)      state_d = continue_song ? ST_LOAD : ST_IDLE;
                    else if (play_end) state_d = ST_GAP;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Output and counter next values, all registered below.
    always_comb begin
        note_div_d  = note_div_q;
        mute_d      = mute_q;
        note_idx_d  = note_idx_q;
        done_d      = 1'b0;
        cnt_d       = cnt_q + CNT_ONE;
        play_last_d = play_last_q;
        playing_d   = (state_d != ST_IDLE);
        if (abort) begin
            mute_d     = 1'b1;
            note_idx_d = '0;
            cnt_d      = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_d = '0;
                    if (start && !stop) note_idx_d = '0;
                end
                ST_LOAD: begin
                    cnt_d       = '0;
                    mute_d      = (rom_pitch == '0);
                    play_last_d = CNT_W'(entry_units(rom_data)) * BEAT_LEN - CNT_ONE;
                    if (rom_pitch != '0) note_div_d = note_div_of(rom_pitch);
                end
                ST_PLAY: begin
                    if (play_end) begin
                        mute_d = 1'b1;
                        cnt_d  = '0;
                    end
                end
                ST_GAP: begin
                    if (gap_end) cnt_d = '0;
                end
                default: cnt_d = '0;
            endcase
            if (note_end) begin
                if (note_idx_q != LAST_IDX) begin
                    note_idx_d = note_idx_q + IDX_ONE;
                end else begin
                    note_idx_d = '0;
                    done_d     = !loop_en;
                end
            end
        end
    end

    // Output and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            note_div_q  <= '0;
            mute_q      <= 1'b1;
            playing_q   <= 1'b0;
            done_q      <= 1'b0;
            note_idx_q  <= '0;
            cnt_q       <= '0;
            play_last_q <= '0;
        end else begin
            note_div_q  <= note_div_d;
            mute_q      <= mute_d;
            playing_q   <= playing_d;
            done_q      <= done_d;
            note_idx_q  <= note_idx_d;
            cnt_q       <= cnt_d;
            play_last_q <= play_last_d;
        end
    end

    assign note_div = note_div_q;
    assign mute     = mute_q;
    assign playing  = playing_q;
    assign done     = done_q;
    assign note_idx = note_idx_q;

endmodule

// File: doc/melody_sequencer.md
MELODY_SEQUENCER -- requirements
Module: melody_sequencer

Interface
REQ-001 The block SHALL have parameter BEAT_DIV, default 10_000_000, meaning clk cycles per duration unit.
REQ-002 The block SHALL have parameter GAP_CYCLES, default 400_000, meaning muted articulation gap between notes, in clk cycles.
REQ-003 The block SHALL have parameter SONG_LEN, default 32, meaning number of ROM entries played, 2..256.
REQ-004 The block SHALL have port clk, input, 1 bit: system clock, 40 MHz crystal.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port start, input, 1 bit: single-cycle pulse that begins playback from entry 0.
REQ-007 The block SHALL have port stop, input, 1 bit: single-cycle pulse that aborts playback.
REQ-008 The block SHALL have port loop_en, input, 1 bit: level; 1 makes playback wrap to entry 0 after the last entry.
REQ-009 The block SHALL have port note_div, output, 20 bits: half-period divider for the tone generator; tone period = 2*(note_div+1) clk cycles.
REQ-010 The block SHALL have port mute, output, 1 bit: 1 means the tone generator output is silenced downstream.
REQ-011 The block SHALL have port playing, output, 1 bit: 1 in every state other than IDLE.
REQ-012 The block SHALL have port note_idx, output, clog2(SONG_LEN) bits: index of the current ROM entry.
REQ-013 The block SHALL have port done, output, 1 bit: single-cycle pulse when a non-looping song completes.

Function
REQ-014 The block SHALL use a ROM entry of 8 bits: [7:4] pitch code, [3:0] duration in units; a duration of 0 SHALL be treated as 1.
REQ-015 Pitch code 0 SHALL be a rest: mute=1 and note_div unchanged. Codes 1..12 SHALL map to C4..B4, and codes 13..15 to C5..D5, through the package table.
REQ-016 The FSM states SHALL be IDLE, LOAD, PLAY, GAP.
REQ-017 In IDLE, start=1 SHALL cause a transition to LOAD with note_idx=0; a stop pulse in IDLE SHALL be ignored.
REQ-018 LOAD SHALL last exactly 1 cycle, covering the registered ROM read latency, and SHALL then go to PLAY.
REQ-019 On entry to PLAY, note_div SHALL be registered from the table, mute SHALL equal (pitch==0), and the cycle counter SHALL clear.
REQ-020 PLAY SHALL last exactly duration*BEAT_DIV cycles and SHALL then go to GAP with mute=1.
REQ-021 GAP SHALL last exactly GAP_CYCLES cycles. If GAP_CYCLES=0, GAP SHALL be skipped.
REQ-022 After GAP, if note_idx<SONG_LEN-1, the block SHALL set note_idx+1 and go to LOAD.
REQ-023 After GAP at the last entry, if loop_en=1, the block SHALL set note_idx=0 and go to LOAD; otherwise it SHALL go to IDLE, pulse done for 1 cycle, and hold mute=1.
REQ-024 loop_en SHALL be sampled only at the last-entry decision point.
REQ-025 stop=1 in any non-IDLE state SHALL force IDLE on the next edge with mute=1 and note_idx=0; no done pulse SHALL be issued.
REQ-026 If start and stop are asserted in the same cycle, stop SHALL win.
REQ-027 start while not in IDLE SHALL be ignored.
REQ-028 The duration counter SHALL be wide enough for 15*BEAT_DIV without wrap.
REQ-029 All outputs SHALL be registered.

Reset
REQ-030 While rst_n=0, the block SHALL hold state IDLE, note_div=20'd0, mute=1, playing=0, note_idx=0, done=0, and all counters 0.
REQ-031 Assertion of rst_n mid-note SHALL abort immediately; after release the block SHALL stay in IDLE until start.

Structure
REQ-032 Package melody_pkg SHALL hold the state enum, the 16-entry pitch-to-note_div table (note_div = 40e6/(2*f)-1, e.g. C4=76443, A4=45453), and the ROM entry field widths.
REQ-033 Sub-module melody_rom SHALL provide a SONG_LEN x 8 synchronous-read ROM with inputs clk and addr, output data, and 1-cycle latency.

Verification (BEAT_DIV=4, GAP_CYCLES=2, SONG_LEN=4, ROM = {A4,d2},{rest,d1},{C4,d0},{B4,d1})
REQ-034 Scenario 1: start pulse, loop_en=0 -> 1 cycle LOAD; note_div=45453 and mute=0 for exactly 8 cycles; mute=1 for 2 cycles; then idx 1.
REQ-035 Scenario 2: entry 1 rest -> mute=1 for the whole 4-cycle PLAY, note_div holds 45453; entry 2 duration 0 -> PLAY lasts 4 cycles with note_div=76443.
REQ-036 Scenario 3: full song, loop_en=0 -> done pulses exactly once, 1 cycle after the last GAP; playing falls in the same cycle; mute=1.
REQ-037 Scenario 4: loop_en=1 -> after entry 3 GAP, note_idx=0 and LOAD; no done pulse; A4 is replayed.
REQ-038 Scenario 5: stop mid-PLAY of entry 2, with start asserted in the same cycle -> IDLE next edge, note_idx=0, mute=1, no done pulse.
REQ-039 Scenario 6: rst_n low during GAP -> all outputs reach their reset values asynchronously; a later start replays from entry 0.
